// File: rtl/deser_frame_ctrl.sv
// Frame sequencer for the two-lane deserializer: buffers the first half-frame,
// streams lane pairs (k, k+N/2), waits for the deserializer and hands the frame to the FFT.
module deser_frame_ctrl #(
    parameter int N       = 8,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16,
    parameter int DW      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [2*DW-1:0]   in_data,
    output logic              in_ready,
    output logic              deser_clear,
    output logic              deser_enable,
    output logic [2*DW-1:0]   deser_data_0,
    output logic [2*DW-1:0]   deser_data_1,
    input  logic              deser_out_valid,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic [CNT_W-1:0]  frame_count,
    output logic              err_timeout,
    output logic              err_proto,
    output logic [2:0]        dbg_state
);

    // Complex samples are packed {re[DW-1:0], im[DW-1:0]}.
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits for ready, and frame_valid holds until frame_ready.
    localparam int HALF = N / 2;
    localparam int KW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int WCW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_CLEAR    = 3'd0,
        S_FILL_LO  = 3'd1,
        S_STREAM   = 3'd2,
        S_WAIT_DES = 3'd3,
        S_HOLD     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic              enable_q, enable_d;
    logic [2*DW-1:0]   data0_q, data0_d;
    logic [2*DW-1:0]   data1_q, data1_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_proto_q, err_proto_d;
    logic              clear_q;
    logic              fvalid_q;
    logic              buf_we;
    logic              accept;
    logic [2*DW-1:0]   lo_buf_q [HALF];

    assign in_ready = ((state_q == S_FILL_LO) || (state_q == S_STREAM)) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        wcnt_d        = wcnt_q;
        enable_d      = 1'b0;
        data0_d       = data0_q;
        data1_d       = data1_q;
        count_d       = count_q;
        err_timeout_d = err_timeout_q;
        err_proto_d   = err_proto_q | (deser_out_valid && (state_q != S_WAIT_DES));
        buf_we        = 1'b0;

        case (state_q)
            S_CLEAR: begin
                state_d = S_FILL_LO;
                k_d     = '0;
            end
            S_FILL_LO: begin
                if (accept) begin
                    buf_we = 1'b1;
                    if (k_q == KW'(HALF - 1)) begin
                        k_d     = '0;
                        state_d = S_STREAM;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            S_STREAM: begin
                if (accept) begin
                    enable_d = 1'b1;
                    data0_d  = lo_buf_q[k_q];
                    data1_d  = in_data;
                    if (k_q == KW'(HALF - 1)) begin
                        k_d     = '0;
                        wcnt_d  = '0;
                        state_d = S_WAIT_DES;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            S_WAIT_DES: begin
                if (deser_out_valid) begin
                    state_d = S_HOLD;
                end else if (wcnt_q == WCW'(TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_CLEAR;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            S_HOLD: begin
                if (frame_ready) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = S_CLEAR;
                end
            end
            default: state_d = S_CLEAR;
        endcase

        // Abort wins over every other event in the cycle, including a timeout.
        if (flush) begin
            state_d       = S_CLEAR;
            enable_d      = 1'b0;
            k_d           = '0;
            count_d       = count_q;
            err_timeout_d = err_timeout_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_CLEAR;
            k_q           <= '0;
            wcnt_q        <= '0;
            enable_q      <= 1'b0;
            data0_q       <= '0;
            data1_q       <= '0;
            count_q       <= '0;
            err_timeout_q <= 1'b0;
            err_proto_q   <= 1'b0;
            clear_q       <= 1'b1;
            fvalid_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            wcnt_q        <= wcnt_d;
            enable_q      <= enable_d;
            data0_q       <= data0_d;
            data1_q       <= data1_d;
            count_q       <= count_d;
            err_timeout_q <= err_timeout_d;
            err_proto_q   <= err_proto_d;
            clear_q       <= (state_d == S_CLEAR);
            fvalid_q      <= (state_d == S_HOLD);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < HALF; i++) begin
                lo_buf_q[i] <= '0;
            end
        end else if (buf_we) begin
            lo_buf_q[k_q] <= in_data;
        end
    end

    assign deser_clear  = clear_q;
    assign deser_enable = enable_q;
    assign deser_data_0 = data0_q;
    assign deser_data_1 = data1_q;
    assign frame_valid  = fvalid_q;
    assign frame_count  = count_q;
    assign err_timeout  = err_timeout_q;
    assign err_proto    = err_proto_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_deser_frame_ctrl.sv
// Self-checking bench for deser_frame_ctrl: frame-level reference model of lane pairs,
// frame count and error flags, plus a small behavioural deserializer.
module tb_deser_frame_ctrl;

    localparam int N       = 8;
    localparam int HALF    = N / 2;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;
    localparam int DW      = 16;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic [2*DW-1:0]   in_data;
    logic              in_ready;
    logic              deser_clear;
    logic              deser_enable;
    logic [2*DW-1:0]   deser_data_0;
    logic [2*DW-1:0]   deser_data_1;
    logic              deser_out_valid;
    logic              frame_valid;
    logic              frame_ready;
    logic [CNT_W-1:0]  frame_count;
    logic              err_timeout;
    logic              err_proto;
    logic [2:0]        dbg_state;

    int checks;
    int errors;

    // Reference model state
    logic [2*DW-1:0]   smp_q[$];
    logic [4*DW-1:0]   exp_q[$];
    bit                exp_en;
    logic [CNT_W-1:0]  exp_count;
    int                des_cnt;
    bit                des_auto;

    deser_frame_ctrl #(
        .N(N), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .DW(DW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .deser_clear(deser_clear),
        .deser_enable(deser_enable),
        .deser_data_0(deser_data_0),
        .deser_data_1(deser_data_1),
        .deser_out_valid(deser_out_valid),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_count(frame_count),
        .err_timeout(err_timeout),
        .err_proto(err_proto),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // One cycle: observe at the falling edge, run the scoreboard and the
    // deserializer model, then return inputs to idle for the caller to override.
    task automatic cyc();
        logic [4*DW-1:0] e;
        @(negedge clk);
        checks++;
        if (deser_enable !== exp_en) begin
            errors++;
            $display("FAIL enable_timing act=%b exp=%b t=%0t", deser_enable, exp_en, $time);
        end
        if (deser_enable === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL lane_pair act=%h_%h exp=<none>", deser_data_0, deser_data_1);
            end else begin
                e = exp_q.pop_front();
                if ({deser_data_0, deser_data_1} !== e) begin
                    errors++;
                    $display("FAIL lane_pair act=%h_%h exp=%h_%h",
                             deser_data_0, deser_data_1, e[4*DW-1:2*DW], e[2*DW-1:0]);
                end
            end
        end
        exp_en = 1'b0;
        if (deser_clear === 1'b1) des_cnt = 0;
        if (deser_enable === 1'b1) des_cnt++;
        deser_out_valid = 1'b0;
        if (des_auto && des_cnt == HALF) begin
            deser_out_valid = 1'b1;
            des_cnt = 0;
        end
        in_valid    = 1'b0;
        frame_ready = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic note_accept(input logic [2*DW-1:0] d);
        int idx;
        checks++;
        if (smp_q.size() >= N) begin
            errors++;
            $display("FAIL accept_overflow act=%0d exp<%0d", smp_q.size() + 1, N + 1);
        end
        smp_q.push_back(d);
        idx = smp_q.size();
        if (idx > HALF) begin
            exp_q.push_back({smp_q[idx - 1 - HALF], d});
            exp_en = 1'b1;
        end
    endtask

    task automatic push_sample(input logic [2*DW-1:0] d, input int gap);
        bit done;
        done = 1'b0;
        for (int g = 0; g < gap; g++) cyc();
        for (int t = 0; t < 20 && !done; t++) begin
            cyc();
            in_valid = 1'b1;
            in_data  = d;
            #1;
            if (in_ready === 1'b1) begin
                done = 1'b1;
                note_accept(d);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_stall act=in_ready_low exp=accept_within_20");
        end
    endtask

    task automatic wait_frame_valid(input int budget);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < budget && !seen; t++) begin
            cyc();
            if (frame_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL frame_valid_wait act=0 exp=1 within %0d", budget);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pairs_missing act=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic take_frame();
        frame_ready = 1'b1;
        cyc();
        exp_count = exp_count + CNT_W'(1);
        smp_q.delete();
        checks++;
        if (frame_count !== exp_count) begin
            errors++;
            $display("FAIL frame_count act=%0d exp=%0d", frame_count, exp_count);
        end
        checks++;
        if (frame_valid !== 1'b0 || deser_clear !== 1'b1) begin
            errors++;
            $display("FAIL after_take act=fv%b_clr%b exp=fv0_clr1", frame_valid, deser_clear);
        end
    endtask

    task automatic run_frame(input int gap_lo, input int gap_hi, input int hold_dly, input bit idx_real);
        logic [2*DW-1:0] d;
        for (int i = 0; i < N; i++) begin
            d = idx_real ? {DW'(i), DW'($urandom)} : 32'($urandom);
            push_sample(d, int'($urandom_range(gap_hi, gap_lo)));
        end
        wait_frame_valid(40);
        for (int h = 0; h < hold_dly; h++) begin
            cyc();
            checks++;
            if (frame_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable act=fv%b_rdy%b exp=fv1_rdy0 cyc=%0d", frame_valid, in_ready, h);
            end
        end
        take_frame();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        cyc();
        checks++;
        if (deser_clear !== 1'b1 || deser_enable !== 1'b0 || frame_valid !== 1'b0 ||
            frame_count !== '0 || err_timeout !== 1'b0 || err_proto !== 1'b0 ||
            deser_data_0 !== '0 || deser_data_1 !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_values act=clr%b en%b fv%b cnt%0d et%b ep%b rdy%b exp=clr1 en0 fv0 cnt0 et0 ep0 rdy0",
                     deser_clear, deser_enable, frame_valid, frame_count, err_timeout, err_proto, in_ready);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (deser_clear !== 1'b1) begin
            errors++;
            $display("FAIL clear_after_release act=%b exp=1", deser_clear);
        end
        cyc();
        checks++;
        if (deser_clear !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_entry act=clr%b_rdy%b exp=clr0_rdy1", deser_clear, in_ready);
        end
    endtask

    task automatic test_basic_frame();
        run_frame(0, 0, 0, 1'b1);
        checks++;
        if (err_proto !== 1'b0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL basic_errs act=et%b_ep%b exp=et0_ep0", err_timeout, err_proto);
        end
    endtask

    task automatic test_gap_stream();
        run_frame(1, 1, 0, 1'b1);
    endtask

    task automatic test_hold_backpressure();
        run_frame(0, 0, 5, 1'b0);
    endtask

    task automatic test_timeout();
        des_auto = 1'b0;
        for (int i = 0; i < N; i++) push_sample(32'($urandom), 0);
        for (int c = 0; c < TIMEOUT; c++) cyc();
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early act=%b exp=0", err_timeout);
        end
        cyc();
        checks++;
        if (err_timeout !== 1'b1 || deser_clear !== 1'b1 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fire act=et%b_clr%b_fv%b exp=et1_clr1_fv0", err_timeout, deser_clear, frame_valid);
        end
        checks++;
        if (frame_count !== exp_count) begin
            errors++;
            $display("FAIL timeout_count act=%0d exp=%0d", frame_count, exp_count);
        end
        smp_q.delete();
        des_auto = 1'b1;
        run_frame(0, 0, 0, 1'b0);
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky act=%b exp=1", err_timeout);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 6; i++) push_sample({DW'(i + 8), DW'($urandom)}, 0);
        cyc();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'($urandom);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready act=%b exp=0", in_ready);
        end
        smp_q.delete();
        cyc();
        checks++;
        if (deser_clear !== 1'b1 || frame_valid !== 1'b0 || frame_count !== exp_count) begin
            errors++;
            $display("FAIL flush_abort act=clr%b_fv%b_cnt%0d exp=clr1_fv0_cnt%0d",
                     deser_clear, frame_valid, frame_count, exp_count);
        end
        run_frame(0, 0, 0, 1'b1);
    endtask

    task automatic test_async_reset_proto();
        for (int i = 0; i < HALF + 1; i++) push_sample(32'($urandom), 0);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (deser_clear !== 1'b1 || deser_enable !== 1'b0 || frame_valid !== 1'b0 ||
            frame_count !== '0 || deser_data_0 !== '0 || deser_data_1 !== '0 ||
            in_ready !== 1'b0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL async_reset act=clr%b en%b fv%b cnt%0d et%b rdy%b exp=clr1 en0 fv0 cnt0 et0 rdy0",
                     deser_clear, deser_enable, frame_valid, frame_count, err_timeout, in_ready);
        end
        exp_en = 1'b0;
        exp_q.delete();
        smp_q.delete();
        exp_count = '0;
        in_valid = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) push_sample(32'($urandom), 0);
        cyc();
        deser_out_valid = 1'b1;
        cyc();
        checks++;
        if (err_proto !== 1'b1 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL proto_flag act=ep%b_fv%b exp=ep1_fv0", err_proto, frame_valid);
        end
        for (int i = 2; i < N; i++) push_sample(32'($urandom), 0);
        wait_frame_valid(40);
        take_frame();
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 6; f++) begin
            run_frame(0, int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), 1'b0);
        end
    endtask

    // ---------------- main ----------------
    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        flush           = 1'b0;
        in_valid        = 1'b0;
        in_data         = '0;
        deser_out_valid = 1'b0;
        frame_ready     = 1'b0;
        exp_en          = 1'b0;
        exp_count       = '0;
        des_cnt         = 0;
        des_auto        = 1'b1;
        #2;
        reset = 1'b0;
        test_reset();
        test_basic_frame();
        test_gap_stream();
        test_hold_backpressure();
        test_timeout();
        test_flush();
        test_async_reset_proto();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
